// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions for the back end.
// Holds the opcode enum, register/word types, the commit FSM state enum
// and the opcode classification helpers that commit and dispatch both use.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    CS_RUN        = 2'd0,
    CS_WAIT_STORE = 2'd1,
    CS_FLUSH      = 2'd2
  } commit_state_t;

  // Instructions whose ROB value lands in the register file at retirement.
  function automatic logic is_regwrite(input lc3b_opcode op);
    case (op)
      op_add, op_and, op_not, op_lea, op_ldb,
      op_ldi, op_ldr, op_shf, op_jsr, op_trap: is_regwrite = 1'b1;
      default:                                 is_regwrite = 1'b0;
    endcase
  endfunction

  // Instructions that must be handed to the store queue before popping.
  function automatic logic is_store(input lc3b_opcode op);
    case (op)
      op_stb, op_sti, op_str: is_store = 1'b1;
      default:                is_store = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/commit_redirect.sv
// Redirect target selection and register for the commit controller.
// Ports:
//   clk, reset_n   - clock, async active-low reset
//   load           - a redirecting instruction pops this cycle
//   is_br          - the popping instruction is a conditional branch
//   head_value     - ROB value; for branches bit0 = taken, [15:1] = target
//   head_pc        - PC of the popping instruction
//   redirect_pc    - registered redirect PC, zero unless a redirect is live
module commit_redirect
  import lc3b_types::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  is_br,
  input  logic [DATA_WIDTH-1:0] head_value,
  input  lc3b_word              head_pc,
  output lc3b_word              redirect_pc
);

  lc3b_word redirect_pc_q, redirect_pc_d;
  lc3b_word target;

  // Taken branches and jumps share the same aligned target; only a
  // not-taken branch falls through (16-bit wrap at 16'hFFFE is intended).
  always_comb begin
    if (is_br && !head_value[0]) target = head_pc + 16'd2;
    else                         target = {head_value[15:1], 1'b0};
    // Cleared when no redirect is being latched, so the output only
    // carries a value during the one flush cycle.
    redirect_pc_d = load ? target : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) redirect_pc_q <= '0;
    else          redirect_pc_q <= redirect_pc_d;
  end

  assign redirect_pc = redirect_pc_q;

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order retirement controller for the reorder buffer.
// Pops completed ROB head entries, writes the regfile, resolves branches
// (BHT update plus one-cycle flush/redirect on mispredict or jump) and
// holds stores at the head until the store queue acknowledges them.
// Ports:
//   clk, reset_n                      - clock, async active-low reset
//   head_*                            - ROB head fields (valid, empty, opcode,
//                                       dest, value, predict, pc, bht index)
//   store_ack                         - store queue performed the head store
//   rob_re                            - pop the ROB head (combinational)
//   reg_we/reg_dest/reg_data          - regfile write port (combinational)
//   bht_update/bht_idx/bht_taken      - branch history update (combinational)
//   store_commit                      - head store request (registered)
//   flush, redirect_valid/redirect_pc - pipeline flush and fetch redirect
//   retired_count                     - number of popped entries, wraps
module rob_commit_ctrl
  import lc3b_types::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  head_valid,
  input  logic                  head_empty,
  input  lc3b_opcode            head_inst,
  input  lc3b_reg               head_dest,
  input  logic [DATA_WIDTH-1:0] head_value,
  input  logic                  head_predict,
  input  lc3b_word              head_pc,
  input  logic [3:0]            head_bht,
  input  logic                  store_ack,
  output logic                  rob_re,
  output logic                  reg_we,
  output lc3b_reg               reg_dest,
  output logic [DATA_WIDTH-1:0] reg_data,
  output logic                  bht_update,
  output logic [3:0]            bht_idx,
  output logic                  bht_taken,
  output logic                  store_commit,
  output logic                  flush,
  output logic                  redirect_valid,
  output lc3b_word              redirect_pc,
  output logic [CNT_WIDTH-1:0]  retired_count
);

  commit_state_t        state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 head_ready;
  logic                 redir_load;

  assign head_ready = !head_empty && head_valid;

  always_comb begin
    state_d    = state_q;
    rob_re     = 1'b0;
    reg_we     = 1'b0;
    reg_dest   = '0;
    reg_data   = '0;
    bht_update = 1'b0;
    bht_idx    = '0;
    bht_taken  = 1'b0;
    redir_load = 1'b0;

    case (state_q)
      CS_RUN: begin
        if (head_ready) begin
          if (is_regwrite(head_inst)) begin
            rob_re   = 1'b1;
            reg_we   = 1'b1;
            reg_dest = head_dest;
            reg_data = head_value;
          end else if (is_store(head_inst)) begin
            // Store stays at the head; it pops only on the ack.
            state_d = CS_WAIT_STORE;
          end else begin
            case (head_inst)
              op_rti: rob_re = 1'b1;
              op_br: begin
                rob_re     = 1'b1;
                bht_update = 1'b1;
                bht_idx    = head_bht;
                bht_taken  = head_value[0];
                if (head_value[0] != head_predict) begin
                  redir_load = 1'b1;
                  state_d    = CS_FLUSH;
                end
              end
              op_jmp: begin
                rob_re     = 1'b1;
                redir_load = 1'b1;
                state_d    = CS_FLUSH;
              end
              default: ;
            endcase
          end
        end
      end

      CS_WAIT_STORE: begin
        // An emptied ROB means the store was squashed; leave without a pop.
        if (head_empty) begin
          state_d = CS_RUN;
        end else if (store_ack) begin
          rob_re  = 1'b1;
          state_d = CS_RUN;
        end
      end

      CS_FLUSH: state_d = CS_RUN;

      default: state_d = CS_RUN;
    endcase

    count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, rob_re};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CS_RUN;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Registered decodes of the current state.
  assign store_commit   = (state_q == CS_WAIT_STORE);
  assign flush          = (state_q == CS_FLUSH);
  assign redirect_valid = (state_q == CS_FLUSH);
  assign retired_count  = count_q;

  commit_redirect #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_redirect (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (redir_load),
    .is_br       (head_inst == op_br),
    .head_value  (head_value),
    .head_pc     (head_pc),
    .redirect_pc (redirect_pc)
  );

endmodule

// File: tb/tb_rob_commit_ctrl.sv
module tb_rob_commit_ctrl;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        head_valid, head_empty, head_predict, store_ack;
  lc3b_opcode  head_inst;
  logic [2:0]  head_dest;
  logic [15:0] head_value, head_pc;
  logic [3:0]  head_bht;
  logic        rob_re, reg_we, bht_update, bht_taken, store_commit;
  logic        flush, redirect_valid;
  logic [2:0]  reg_dest;
  logic [15:0] reg_data, redirect_pc, retired_count;
  logic [3:0]  bht_idx;

  always #5 clk = ~clk;

  rob_commit_ctrl #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .head_valid(head_valid), .head_empty(head_empty), .head_inst(head_inst),
    .head_dest(head_dest), .head_value(head_value), .head_predict(head_predict),
    .head_pc(head_pc), .head_bht(head_bht), .store_ack(store_ack),
    .rob_re(rob_re), .reg_we(reg_we), .reg_dest(reg_dest), .reg_data(reg_data),
    .bht_update(bht_update), .bht_idx(bht_idx), .bht_taken(bht_taken),
    .store_commit(store_commit), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .retired_count(retired_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a pending-redirect slot, a "store outstanding" flag
  // and a retirement tally.
  bit          m_flush, n_flush;
  logic [15:0] m_redir, n_redir;
  bit          m_store, n_store;
  logic [15:0] m_cnt, n_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_flush = 0; m_redir = '0; m_store = 0; m_cnt = '0;
  endtask

  task automatic check_cycle();
    bit e_re, e_we, e_bu, e_sc, e_fl;
    e_re = 0; e_we = 0; e_bu = 0; e_sc = 0; e_fl = 0;
    n_flush = 0; n_redir = m_redir; n_store = m_store; n_cnt = m_cnt;
    if (m_flush) begin
      e_fl = 1;
    end else if (m_store) begin
      e_sc = 1;
      if (head_empty) n_store = 0;
      else if (store_ack) begin e_re = 1; n_store = 0; end
    end else if (!head_empty && head_valid) begin
      case (head_inst)
        op_add, op_and, op_not, op_lea, op_ldb, op_ldi, op_ldr, op_shf, op_jsr, op_trap: begin
          e_re = 1; e_we = 1;
        end
        op_rti: e_re = 1;
        op_br: begin
          e_re = 1; e_bu = 1;
          if (head_value[0] != head_predict) begin
            n_flush = 1;
            n_redir = head_value[0] ? {head_value[15:1], 1'b0} : head_pc + 16'd2;
          end
        end
        op_jmp: begin
          e_re = 1; n_flush = 1; n_redir = head_value & 16'hFFFE;
        end
        default: n_store = 1;
      endcase
    end
    if (e_re) n_cnt = m_cnt + 16'd1;

    chk("rob_re", 32'(rob_re), 32'(e_re));
    chk("reg_we", 32'(reg_we), 32'(e_we));
    if (e_we) begin
      chk("reg_dest", 32'(reg_dest), 32'(head_dest));
      chk("reg_data", 32'(reg_data), 32'(head_value));
    end
    chk("bht_update", 32'(bht_update), 32'(e_bu));
    if (e_bu) begin
      chk("bht_idx", 32'(bht_idx), 32'(head_bht));
      chk("bht_taken", 32'(bht_taken), 32'(head_value[0]));
    end
    chk("store_commit", 32'(store_commit), 32'(e_sc));
    chk("flush", 32'(flush), 32'(e_fl));
    chk("redirect_valid", 32'(redirect_valid), 32'(e_fl));
    if (e_fl) chk("redirect_pc", 32'(redirect_pc), 32'(m_redir));
    chk("retired_count", 32'(retired_count), 32'(m_cnt));
  endtask

  // Called at a negedge with inputs already driven.
  task automatic step();
    #2;
    check_cycle();
    @(posedge clk);
    m_flush = n_flush; m_redir = n_redir; m_store = n_store; m_cnt = n_cnt;
    @(negedge clk);
  endtask

  task automatic set_head(input lc3b_opcode op, input logic [2:0] dest,
                          input logic [15:0] val, input logic pred,
                          input logic [15:0] pc, input logic [3:0] bht);
    head_inst = op; head_dest = dest; head_value = val; head_predict = pred;
    head_pc = pc; head_bht = bht; head_valid = 1'b1; head_empty = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; store_ack = 1'b0;
    set_head(op_add, 3'd0, 16'h0, 1'b0, 16'h0, 4'h0);
    head_empty = 1'b1; head_valid = 1'b0;
    model_reset();
    #3;
    check_cycle();                      // reset values
    @(negedge clk);
    reset_n = 1'b1;

    // Register writer
    set_head(op_add, 3'd3, 16'h1234, 1'b0, 16'h1000, 4'h2);
    step();
    head_empty = 1'b1;
    step();

    // Branch predicted taken, actually not taken -> fallthrough redirect
    set_head(op_br, 3'd0, 16'h3000, 1'b1, 16'h3000, 4'h5);
    step();
    head_empty = 1'b1;
    step();
    step();

    // Branch predicted not taken, actually taken -> target redirect
    set_head(op_br, 3'd0, 16'h4021, 1'b0, 16'h2000, 4'hA);
    step();
    head_empty = 1'b1;
    step();
    // Same branch correctly predicted -> no flush
    set_head(op_br, 3'd0, 16'h4021, 1'b1, 16'h2000, 4'hA);
    step();
    head_empty = 1'b1;
    step();

    // Jump and fallthrough wrap at 16'hFFFE
    set_head(op_jmp, 3'd0, 16'h5557, 1'b0, 16'h0100, 4'h0);
    step();
    head_empty = 1'b1;
    step();
    set_head(op_br, 3'd0, 16'h0000, 1'b1, 16'hFFFE, 4'h1);
    step();
    head_empty = 1'b1;
    step();

    // Store with ack held low for 3 cycles
    set_head(op_str, 3'd0, 16'h0, 1'b0, 16'h0, 4'h0);
    store_ack = 1'b0;
    step();
    repeat (3) step();
    store_ack = 1'b1;
    step();
    store_ack = 1'b0; head_empty = 1'b1;
    step();

    // Not-ready heads
    set_head(op_add, 3'd1, 16'hBEEF, 1'b0, 16'h0, 4'h0);
    head_empty = 1'b1;
    step();
    head_empty = 1'b0; head_valid = 1'b0;
    step();

    // ROB emptied while waiting on a store
    set_head(op_sti, 3'd0, 16'h0, 1'b0, 16'h0, 4'h0);
    step();
    head_empty = 1'b1; store_ack = 1'b1;
    step();
    store_ack = 1'b0;
    step();

    // Async reset mid-WAIT_STORE
    set_head(op_stb, 3'd0, 16'h0, 1'b0, 16'h0, 4'h0);
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_cycle();
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      head_inst    = lc3b_opcode'(4'($urandom_range(0, 15)));
      head_dest    = 3'($urandom);
      head_value   = 16'($urandom);
      head_predict = 1'($urandom);
      head_pc      = 16'($urandom);
      head_bht     = 4'($urandom);
      head_valid   = ($urandom_range(0, 9) != 0);
      head_empty   = ($urandom_range(0, 9) == 0);
      store_ack    = ($urandom_range(0, 2) == 0);
      step();
    end

    // Counter wrap after 2^16 retirements from reset
    store_ack = 1'b0;
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    set_head(op_and, 3'd2, 16'h0F0F, 1'b0, 16'h0, 4'h0);
    repeat (65535) @(posedge clk);
    @(negedge clk);
    #2 chk("count_pre_wrap", 32'(retired_count), 32'hFFFF);
    @(posedge clk);
    @(negedge clk);
    head_empty = 1'b1;
    #2 chk("count_wrap", 32'(retired_count), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_commit_ctrl.md
# rob_commit_ctrl

In-order retirement controller for the reorder buffer. It watches the ROB head and pops completed entries. For each popped entry it writes the register file, resolves branches and updates the BHT. On a mispredict it raises a one-cycle pipeline flush with a redirect PC. Stores are held at the head until the memory stage acknowledges them. It sits between `reorder_buffer` (head outputs and RE) and the regfile, fetch and store-queue logic.

## Interface
- `DATA_WIDTH`, 16: width of ROB value field and register data.
- `CNT_WIDTH`, 16: width of retired-instruction counter.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `head_valid`  in  1  ROB head value ready (`valid_out`).
- `head_empty`  in  1  ROB empty (`empty_out`).
- `head_inst`  in  `lc3b_opcode`  head opcode.
- `head_dest`  in  `lc3b_reg`  head destination register.
- `head_value`  in  `DATA_WIDTH`  head result; for `op_br`, bit0 = actual taken and [15:1] = target[15:1].
- `head_predict`  in  1  predicted taken.
- `head_pc`  in  `lc3b_word`  original PC of head.
- `head_bht`  in  4  BHT index of head.
- `store_ack`  in  1  store queue has performed the committed store.
- `rob_re`  out  1  pop ROB head this cycle.
- `reg_we`, `reg_dest`, `reg_data`  out  1 / 3 / `DATA_WIDTH`  regfile write port.
- `bht_update`, `bht_idx`, `bht_taken`  out  1 / 4 / 1  branch history update.
- `store_commit`  out  1  request head store to memory.
- `flush`  out  1  flush ROB, reservation stations and fetch.
- `redirect_valid`, `redirect_pc`  out  1 / 16  fetch redirect.
- `retired_count`  out  `CNT_WIDTH`  count of popped entries.

## Operation
- States: RUN, WAIT_STORE, FLUSH. Reset puts the controller in RUN.
- Reset values: all outputs 0 and `retired_count` = 0.
- A head is *ready* when `head_empty`=0 and `head_valid`=1. If the head is not ready, the controller stalls with all pulses 0.
- RUN, ready head, classified by opcode:
  - Register writers (`op_add`, `op_and`, `op_not`, `op_lea`, `op_ldb`, `op_ldi`, `op_ldr`, `op_shf`, `op_jsr`, `op_trap`): `rob_re`=1, `reg_we`=1, `reg_dest`=`head_dest`, `reg_data`=`head_value`. Stay in RUN.
  - `op_rti`: pop only.
  - `op_br`: pop; `bht_update`=1, `bht_idx`=`head_bht`, `bht_taken`=`head_value[0]`.
    - If `head_value[0]` == `head_predict`: stay in RUN.
    - Otherwise latch `redirect_pc` (see below) and go to FLUSH.
  - `op_br` redirect PC: `{head_value[15:1],1'b0}` if taken, else `head_pc`+2.
  - `op_jmp`: pop; latch `redirect_pc` = `head_value` & 16'hFFFE; go to FLUSH.
  - `op_stb`, `op_sti`, `op_str`: no pop; go to WAIT_STORE.
- WAIT_STORE:
  - `store_commit`=1 every cycle.
  - On `store_ack`=1: `rob_re`=1 in that same cycle, then return to RUN.
  - A store pops only in the cycle `store_ack` is seen.
- FLUSH: lasts exactly one cycle.
  - `flush`=1, `redirect_valid`=1, `redirect_pc` driven from the latched value.
  - `rob_re`=0 and the head is ignored.
  - Next state is RUN.
- `retired_count` increments by 1 on every cycle with `rob_re`=1. It wraps modulo 2^`CNT_WIDTH` and is not cleared by flush.
- `redirect_pc` arithmetic is 16-bit modulo; `head_pc`=16'hFFFE gives 16'h0000.

## Timing
- RUN outputs `rob_re`, `reg_*`, `bht_*` are combinational (Mealy) from state and head fields. Throughput is one retirement per cycle; the ROB pops at the same clock edge.
- `flush`, `redirect_valid` and `redirect_pc` are registered: asserted in the cycle after the mispredicting branch pops.
- `store_commit` is a registered state decode: first high in the cycle after the store reaches the head in RUN.
- If `store_ack` and `reset_n` deassertion coincide, reset wins. An async reset mid-WAIT_STORE or mid-FLUSH returns to RUN with every output 0 immediately.
- `store_ack` outside WAIT_STORE is ignored.
- A ready head that becomes not ready (flushed) while in WAIT_STORE is not possible by construction. If `head_empty` rises in WAIT_STORE, the controller returns to RUN without popping.

## Structure
- Opcode classification (`is_regwrite`, `is_store`) goes in `lc3b_types` as functions or constants, shared with dispatch.
- The state enum `commit_state_t` goes in `lc3b_types`.
- Single module. An optional sub-module `commit_redirect` holds the branch target/fallthrough mux and redirect register.

## Test plan
- `op_add` R3 = 16'h1234 ready at head in RUN -> same cycle `rob_re`=1, `reg_we`=1, `reg_dest`=3, `reg_data`=16'h1234; `retired_count` goes 0 -> 1.
- `op_br` at `head_pc` 16'h3000, predict=1, `head_value`=16'h3000 (not taken) -> pop and `bht_update` with taken=0; next cycle `flush`=1, `redirect_pc`=16'h3002 for exactly one cycle.
- `op_br` predict=0, `head_value`=16'h4021 -> `redirect_pc`=16'h4020. Repeat with predict=1 -> no flush.
- `op_str` at head with `store_ack` held low for 3 cycles -> `store_commit` high from cycle 1; no pop until the ack cycle, then `rob_re`=1 exactly once.
- Empty ROB, or head with `head_valid`=0 -> all pulses 0 and count unchanged. Assert `reset_n`=0 mid-WAIT_STORE -> outputs 0 asynchronously, state RUN.
- Retire 2^16 entries -> `retired_count` wraps to 0.
